// File: rtl/fixture_picobello_top.sv
// Boot/preload sequencer: latches modes on start, steps the chip through init/preload/run, then polls for EOC.
// One command in flight; cmd_valid_o held stable until cmd_ready_i, next command only after its response.
module fixture_picobello_top #(
  parameter int PollInterval = 16,
  parameter int MaxPolls     = 0
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [1:0]  boot_mode_i,
  input  logic [1:0]  preload_mode_i,
  input  logic        sn_preload_i,
  input  logic        dut_rst_done_i,
  output logic [1:0]  boot_mode_o,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [2:0]  cmd_op_o,
  output logic [1:0]  cmd_port_o,
  input  logic        rsp_valid_i,
  input  logic [31:0] rsp_data_i,
  input  logic        uart_reading_byte_i,
  output logic        busy_o,
  output logic        done_o,
  output logic [31:0] exit_code_o,
  output logic        error_o,
  output logic [2:0]  error_code_o
);

  typedef enum logic [3:0] {
    IDLE, WAIT_RST, INIT, SN_PRELOAD, RUN, POLL_WAIT, POLL, FAST_READ, UART_DRAIN, DONE, ERROR
  } state_e;

  localparam logic [2:0] OpInit = 3'd0, OpSnPreload = 3'd1, OpRun = 3'd2, OpPoll = 3'd3, OpFastRead = 3'd4;
  localparam logic [1:0] PortJtag = 2'd0, PortSlink = 2'd1, PortUart = 2'd2, PortFast = 2'd3;
  localparam logic [15:0] WaitLast  = 16'(PollInterval - 1);
  localparam logic [15:0] PollLimit = 16'(MaxPolls);

  state_e      state_q, state_d;
  logic [2:0]  err_code_q, err_code_d;
  logic [1:0]  boot_q, preload_q;
  logic        sn_q;
  logic        cmd_sent_q;
  logic [15:0] poll_cnt_q, wait_cnt_q;
  logic [31:0] exit_code_q;

  logic        start_ok, in_cmd, cmd_vld, rsp_fire, eoc, poll_miss, poll_limit, fast_read_due;
  logic [1:0]  run_port, sn_port;

  assign start_ok      = start_i && (state_q inside {IDLE, DONE, ERROR});
  assign in_cmd        = state_q inside {INIT, SN_PRELOAD, RUN, POLL, FAST_READ};
  assign cmd_vld       = in_cmd && !cmd_sent_q;
  // Responses only count once the command has actually been accepted.
  assign rsp_fire      = in_cmd && cmd_sent_q && rsp_valid_i;
  assign eoc           = rsp_fire && (state_q == POLL) && rsp_data_i[0];
  assign poll_miss     = rsp_fire && (state_q == POLL) && !rsp_data_i[0];
  assign poll_limit    = (MaxPolls > 0) && ((poll_cnt_q + 16'd1) == PollLimit);
  assign fast_read_due = !boot_q[1] && (preload_q == 2'd3) && sn_q;

  always_comb begin
    run_port = PortJtag;
    sn_port  = PortJtag;
    if (!boot_q[1]) begin
      case (preload_q)
        2'd1:    begin run_port = PortSlink; sn_port = PortSlink; end
        2'd2:    run_port = PortUart;
        2'd3:    sn_port  = PortFast;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      err_code_q <= 3'd0;
    end else begin
      state_q    <= state_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    err_code_d = err_code_q;
    if (start_ok) begin
      state_d    = WAIT_RST;
      err_code_d = 3'd0;
    end else begin
      case (state_q)
        WAIT_RST: if (dut_rst_done_i) begin
          if (boot_q == 2'd1) begin
            state_d    = ERROR;
            err_code_d = 3'd2;
          end else if (boot_q[1]) begin
            state_d = INIT;
          end else begin
            case (preload_q)
              2'd1: state_d = sn_q ? SN_PRELOAD : RUN;
              2'd2: begin
                if (sn_q) begin
                  state_d    = ERROR;
                  err_code_d = 3'd1;
                end else begin
                  state_d = RUN;
                end
              end
              default: state_d = INIT;
            endcase
          end
        end
        INIT:       if (rsp_fire) state_d = boot_q[1] ? POLL : (sn_q ? SN_PRELOAD : RUN);
        SN_PRELOAD: if (rsp_fire) state_d = RUN;
        RUN:        if (rsp_fire) state_d = POLL;
        POLL: begin
          if (eoc) begin
            state_d = fast_read_due ? FAST_READ : (uart_reading_byte_i ? UART_DRAIN : DONE);
          end else if (poll_miss) begin
            if (poll_limit) begin
              state_d    = ERROR;
              err_code_d = 3'd3;
            end else begin
              state_d = POLL_WAIT;
            end
          end
        end
        POLL_WAIT:  if (wait_cnt_q == WaitLast) state_d = POLL;
        FAST_READ:  if (rsp_fire) state_d = uart_reading_byte_i ? UART_DRAIN : DONE;
        UART_DRAIN: if (!uart_reading_byte_i) state_d = DONE;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      boot_q      <= 2'd0;
      preload_q   <= 2'd0;
      sn_q        <= 1'b0;
      cmd_sent_q  <= 1'b0;
      poll_cnt_q  <= 16'd0;
      wait_cnt_q  <= 16'd0;
      exit_code_q <= 32'd0;
    end else begin
      if (start_ok) begin
        boot_q      <= boot_mode_i;
        preload_q   <= preload_mode_i;
        sn_q        <= sn_preload_i;
        poll_cnt_q  <= 16'd0;
        exit_code_q <= 32'd0;
      end else begin
        if (eoc)       exit_code_q <= {1'b0, rsp_data_i[31:1]};
        if (poll_miss) poll_cnt_q  <= poll_cnt_q + 16'd1;
      end
      // Every command state is left on its response, so a state change re-arms the issue flag.
      if (state_d != state_q)          cmd_sent_q <= 1'b0;
      else if (cmd_vld && cmd_ready_i) cmd_sent_q <= 1'b1;
      if ((state_q == POLL_WAIT) && (state_d == POLL_WAIT)) wait_cnt_q <= wait_cnt_q + 16'd1;
      else                                                  wait_cnt_q <= 16'd0;
    end
  end

  always_comb begin
    cmd_valid_o  = cmd_vld;
    cmd_op_o     = OpInit;
    cmd_port_o   = PortJtag;
    if (cmd_vld) begin
      case (state_q)
        SN_PRELOAD: begin cmd_op_o = OpSnPreload; cmd_port_o = sn_port;  end
        RUN:        begin cmd_op_o = OpRun;       cmd_port_o = run_port; end
        POLL:       begin cmd_op_o = OpPoll;      cmd_port_o = run_port; end
        FAST_READ:  begin cmd_op_o = OpFastRead;  cmd_port_o = PortFast; end
        default: ;
      endcase
    end
    boot_mode_o  = boot_q;
    exit_code_o  = exit_code_q;
    busy_o       = !(state_q inside {IDLE, DONE, ERROR});
    done_o       = (state_q == DONE);
    error_o      = (state_q == ERROR);
    error_code_o = (state_q == ERROR) ? err_code_q : 3'd0;
  end

endmodule

// File: tb/tb_fixture_picobello_top.sv
// Randomized bench for fixture_picobello_top: a transport agent answers commands, a step-list model predicts them.
module tb_fixture_picobello_top;

  localparam int PI = 5;
  localparam int MP = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  boot_in = 2'd0, preload_in = 2'd0;
  logic        sn_in = 1'b0, rst_done = 1'b0;
  logic [1:0]  boot_out;
  logic        cmd_valid, cmd_ready = 1'b0;
  logic [2:0]  cmd_op;
  logic [1:0]  cmd_port;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data = 32'd0;
  logic        uart_busy = 1'b0;
  logic        busy, done, error;
  logic [31:0] exit_code;
  logic [2:0]  error_code;

  int vectors = 0;
  int miscompares = 0;

  fixture_picobello_top #(.PollInterval(PI), .MaxPolls(MP)) dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .boot_mode_i(boot_in),
    .preload_mode_i(preload_in), .sn_preload_i(sn_in), .dut_rst_done_i(rst_done),
    .boot_mode_o(boot_out), .cmd_valid_o(cmd_valid), .cmd_ready_i(cmd_ready),
    .cmd_op_o(cmd_op), .cmd_port_o(cmd_port), .rsp_valid_i(rsp_valid), .rsp_data_i(rsp_data),
    .uart_reading_byte_i(uart_busy), .busy_o(busy), .done_o(done), .exit_code_o(exit_code),
    .error_o(error), .error_code_o(error_code)
  );

  always #5 clk = ~clk;

  // Transport agent state
  logic [2:0]  obs_op[$];
  logic [1:0]  obs_port[$];
  int          vld_cyc[$];
  int          rsp_cyc[$];
  logic [31:0] poll_plan[$];
  int  cyc = 0;
  bit  pending = 0;
  int  rsp_delay = 0;
  logic [2:0] pend_op = 3'd0;
  int  stall_n = 0;
  int  stall_cnt = 0;
  bit  prev_vld = 0;
  bit  stray_en = 0;

  // Expected command list
  logic [2:0] exp_op[$];
  logic [1:0] exp_port[$];

  initial begin : agent
    forever begin
      @(negedge clk);
      cyc++;
      rsp_valid = 1'b0;
      if (!rst_n) begin
        pending = 0; cmd_ready = 1'b0; stall_cnt = 0; prev_vld = 0;
        continue;
      end
      if (pending) begin
        if (rsp_delay == 0) begin
          rsp_valid = 1'b1;
          if (pend_op == 3'd3) rsp_data = (poll_plan.size() > 0) ? poll_plan.pop_front() : 32'h1;
          else                 rsp_data = $urandom;
          rsp_cyc.push_back(cyc);
          pending = 0;
        end else begin
          rsp_delay--;
        end
      end else if (stray_en && $urandom_range(0, 7) == 0) begin
        rsp_valid = 1'b1;
        rsp_data  = $urandom | 32'h1;
      end
      if (cmd_valid && !prev_vld) vld_cyc.push_back(cyc);
      cmd_ready = 1'b0;
      if (cmd_valid) begin
        if (stall_cnt < stall_n) stall_cnt++;
        else cmd_ready = (stall_n > 0) ? 1'b1 : ($urandom_range(0, 3) != 0);
      end
      if (cmd_valid && cmd_ready) begin
        obs_op.push_back(cmd_op);
        obs_port.push_back(cmd_port);
        pending   = 1;
        pend_op   = cmd_op;
        rsp_delay = $urandom_range(0, 3);
        stall_cnt = 0;
      end
      prev_vld = cmd_valid;
    end
  end

  task automatic push_cmd(input logic [2:0] op, input logic [1:0] port);
    exp_op.push_back(op);
    exp_port.push_back(port);
  endtask

  // Step list straight from the boot/preload rules; polls = misses+1 unless the poll limit cuts it short.
  task automatic model(input logic [1:0] b, input logic [1:0] p, input bit sn, input int misses,
                       output int err);
    int  npoll;
    bit  timeout;
    logic [1:0] pp;
    exp_op.delete(); exp_port.delete();
    err     = 0;
    timeout = (MP > 0) && (misses >= MP);
    npoll   = timeout ? MP : misses + 1;
    if (b == 2'd1) begin err = 2; return; end
    if (b == 2'd0 && p == 2'd2 && sn) begin err = 1; return; end
    if (b >= 2'd2) begin
      push_cmd(3'd0, 2'd0);
      repeat (npoll) push_cmd(3'd3, 2'd0);
    end else begin
      pp = (p == 2'd3) ? 2'd0 : p;
      if (p == 2'd0 || p == 2'd3) push_cmd(3'd0, 2'd0);
      if (sn) push_cmd(3'd1, p);
      push_cmd(3'd2, pp);
      repeat (npoll) push_cmd(3'd3, pp);
      if (p == 2'd3 && sn && !timeout) push_cmd(3'd4, 2'd3);
    end
    if (timeout) err = 3;
  endtask

  task automatic run_case(input string name, input logic [1:0] b, input logic [1:0] p, input bit sn,
                          input int misses, input logic [31:0] eoc);
    int err;
    int t;
    int bad;
    model(b, p, sn, misses, err);
    poll_plan.delete();
    for (int i = 0; i < misses; i++) poll_plan.push_back($urandom & 32'hFFFF_FFFE);
    poll_plan.push_back(eoc | 32'h1);
    obs_op.delete(); obs_port.delete(); vld_cyc.delete(); rsp_cyc.delete();
    rst_done = 1'b0;
    @(negedge clk);
    start = 1'b1; boot_in = b; preload_in = p; sn_in = sn;
    @(negedge clk);
    start = 1'b0; boot_in = 2'($urandom); preload_in = 2'($urandom); sn_in = 1'($urandom);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0 || error !== 1'b0 || exit_code !== 32'd0 || boot_out !== b) begin
      miscompares++;
      $display("FAIL %s start: busy=%b done=%b err=%b exit=%h boot=%0d, want 1 0 0 0 %0d",
               name, busy, done, error, exit_code, boot_out, b);
    end
    repeat ($urandom_range(0, 3)) @(negedge clk);
    rst_done = 1'b1;
    t = 0;
    while (!(done || error) && t < 3000) begin
      if (t == 4 && busy) begin
        start = 1'b1; boot_in = 2'($urandom); preload_in = 2'($urandom); sn_in = 1'($urandom);
        @(negedge clk);
        start = 1'b0;
      end else begin
        @(negedge clk);
      end
      t++;
    end
    vectors++;
    if (t >= 3000) begin
      miscompares++;
      $display("FAIL %s timeout: no done/error after %0d cycles", name, t);
    end
    vectors++;
    if (obs_op.size() != exp_op.size()) begin
      miscompares++;
      $display("FAIL %s cmd_count: got %0d, want %0d", name, obs_op.size(), exp_op.size());
    end
    for (int i = 0; i < exp_op.size() && i < obs_op.size(); i++) begin
      vectors++;
      if (obs_op[i] !== exp_op[i] || obs_port[i] !== exp_port[i]) begin
        miscompares++;
        $display("FAIL %s cmd[%0d]: got op=%0d port=%0d, want op=%0d port=%0d",
                 name, i, obs_op[i], obs_port[i], exp_op[i], exp_port[i]);
      end
    end
    vectors++;
    if (err != 0) begin
      if (error !== 1'b1 || done !== 1'b0 || error_code !== 3'(err) || exit_code !== 32'd0) begin
        miscompares++;
        $display("FAIL %s error_end: err=%b done=%b code=%0d exit=%h, want 1 0 %0d 0",
                 name, error, done, error_code, exit_code, err);
      end
    end else begin
      if (done !== 1'b1 || error !== 1'b0 || error_code !== 3'd0 || exit_code !== ((eoc | 32'h1) >> 1)) begin
        miscompares++;
        $display("FAIL %s done_end: done=%b err=%b code=%0d exit=%h, want 1 0 0 %h",
                 name, done, error, error_code, exit_code, (eoc | 32'h1) >> 1);
      end
    end
    vectors++;
    if (busy !== 1'b0 || boot_out !== b) begin
      miscompares++;
      $display("FAIL %s idle_end: busy=%b boot=%0d, want 0 %0d", name, busy, boot_out, b);
    end
    bad = 0;
    for (int i = 1; i < obs_op.size() && i < vld_cyc.size() && i <= rsp_cyc.size(); i++) begin
      if (obs_op[i] == 3'd3 && obs_op[i-1] == 3'd3) begin
        vectors++;
        if (vld_cyc[i] - rsp_cyc[i-1] != PI + 1) begin
          miscompares++;
          $display("FAIL %s poll_gap[%0d]: got %0d cycles, want %0d", name, i, vld_cyc[i] - rsp_cyc[i-1], PI + 1);
        end
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 0 || done !== 0 || error !== 0 || error_code !== 0 || exit_code !== 0 ||
        boot_out !== 0 || cmd_valid !== 0 || cmd_op !== 0 || cmd_port !== 0) begin
      miscompares++;
      $display("FAIL reset_state: busy=%b done=%b err=%b code=%0d exit=%h boot=%0d vld=%b, want all 0",
               busy, done, error, error_code, exit_code, boot_out, cmd_valid);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_directed;
    run_case("slink_sn", 2'd0, 2'd1, 1'b1, 1, 32'h0000_0001);
    run_case("jtag_exit3", 2'd0, 2'd0, 1'b0, 0, 32'h0000_0007);
    run_case("boot_sd", 2'd1, 2'd0, 1'b0, 0, 32'h1);
    run_case("uart_sn", 2'd0, 2'd2, 1'b1, 0, 32'h1);
    run_case("poll_limit", 2'd2, 2'd0, 1'b0, 5, 32'h1);
  endtask

  task automatic test_stall;
    int held;
    logic [2:0] op0;
    logic [1:0] port0;
    stall_n = 5;
    fork
      run_case("fast_stall", 2'd0, 2'd3, 1'b1, 0, 32'hABCD_0003);
      begin
        int w;
        w = 0;
        while (!cmd_valid && w < 100) begin @(negedge clk); w++; end
        op0 = cmd_op; port0 = cmd_port;
        vectors++;
        if (op0 !== 3'd0 || port0 !== 2'd0) begin
          miscompares++;
          $display("FAIL stall_first_cmd: got op=%0d port=%0d, want 0 0", op0, port0);
        end
        held = 0;
        while (cmd_valid && held < 20) begin
          vectors++;
          if (cmd_op !== op0 || cmd_port !== port0) begin
            miscompares++;
            $display("FAIL stall_stable: got op=%0d port=%0d, want %0d %0d", cmd_op, cmd_port, op0, port0);
          end
          held++;
          @(negedge clk);
        end
        vectors++;
        if (held != stall_n + 1) begin
          miscompares++;
          $display("FAIL stall_hold: valid held %0d cycles, want %0d", held, stall_n + 1);
        end
      end
    join
    stall_n = 0;
  endtask

  task automatic test_random;
    for (int n = 0; n < 14; n++) begin
      stray_en = 1;
      run_case("random", 2'($urandom), 2'($urandom), 1'($urandom), $urandom_range(0, 3), $urandom);
    end
    stray_en = 0;
  endtask

  task automatic drain_start(input logic [31:0] eoc);
    int t;
    poll_plan.delete(); poll_plan.push_back(eoc);
    obs_op.delete(); obs_port.delete(); vld_cyc.delete(); rsp_cyc.delete();
    uart_busy = 1'b1;
    rst_done  = 1'b1;
    @(negedge clk);
    start = 1'b1; boot_in = 2'd0; preload_in = 2'd2; sn_in = 1'b0;
    @(negedge clk);
    start = 1'b0;
    t = 0;
    while (rsp_cyc.size() < 2 && t < 200) begin @(negedge clk); t++; end
    repeat (3) @(negedge clk);
    vectors++;
    if (busy !== 1'b1 || done !== 1'b0 || exit_code !== (eoc >> 1)) begin
      miscompares++;
      $display("FAIL drain_hold: busy=%b done=%b exit=%h, want 1 0 %h", busy, done, exit_code, eoc >> 1);
    end
  endtask

  task automatic test_uart_drain;
    drain_start(32'h0000_0041);
    uart_busy = 1'b0;
    @(negedge clk);
    vectors++;
    if (done !== 1'b1 || busy !== 1'b0 || exit_code !== 32'h20) begin
      miscompares++;
      $display("FAIL drain_release: done=%b busy=%b exit=%h, want 1 0 20", done, busy, exit_code);
    end
    drain_start(32'h0000_0013);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if (busy !== 0 || done !== 0 || error !== 0 || exit_code !== 0 || boot_out !== 0 || cmd_valid !== 0) begin
      miscompares++;
      $display("FAIL drain_reset: busy=%b done=%b err=%b exit=%h boot=%0d vld=%b, want all 0",
               busy, done, error, exit_code, boot_out, cmd_valid);
    end
    uart_busy = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_case("after_reset", 2'd0, 2'd1, 1'b0, 1, 32'h0000_0005);
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_random();
    test_uart_drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
